jtpang_vtiming: RTL

JTPANG_VTIMING -- requirements
Module: jtpang_vtiming

---
 rtl/jtpang_vtiming.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jtpang_vtiming.sv
// ---------------------------------------------------------------------------
// jtpang_vtiming
//   Video timing generator: 9-bit H/V raster counters, blanking and sync
//   strobes, flipped coordinates and NIRQ raster-line interrupt channels.
//
//   Optional build macro: JTPANG_IRQACK_EN
//     defined   : a pending flag is held until its irq_ack bit is seen
//     undefined : a pending flag lasts exactly one line; irq_ack is ignored
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   pxl_cen   in   pixel clock enable; all raster state advances only here
//   flip      in   screen flip, applied combinationally to hf/vf
//   irq_en    in   [NIRQ] per-channel interrupt mask (only gates int_n)
//   irq_ack   in   [NIRQ] per-channel acknowledge (JTPANG_IRQACK_EN only)
//   h, v      out  [9]  horizontal / vertical counters
//   hf        out  [9]  h XOR flip
//   vf        out  [8]  v[7:0] XOR flip
//   LHBL      out  high during active horizontal region
//   LVBL      out  high during active vertical region
//   HS, VS    out  horizontal / vertical sync
//   irq_pend  out  [NIRQ] pending flags
//   int_n     out  registered, active-low OR of enabled pending flags
// ---------------------------------------------------------------------------
module jtpang_vtiming #(
  parameter logic [8:0]          HCNT_END  = 9'd511,
  parameter logic [8:0]          HB_START  = 9'd447,
  parameter logic [8:0]          HB_END    = 9'd63,
  parameter logic [8:0]          HS_START  = 9'd495,
  parameter logic [8:0]          HS_END    = 9'd31,
  parameter logic [8:0]          VCNT_END  = 9'd263,
  parameter logic [8:0]          VB_START  = 9'd240,
  parameter logic [8:0]          VB_END    = 9'd0,
  parameter logic [8:0]          VS_START  = 9'd244,
  parameter logic [8:0]          VS_END    = 9'd247,
  parameter int                  NIRQ      = 2,
  parameter logic [NIRQ*9-1:0]   IRQ_LINES = {9'd240, 9'd96}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic            flip,
  input  logic [NIRQ-1:0] irq_en,
  input  logic [NIRQ-1:0] irq_ack,
  output logic [8:0]      h,
  output logic [8:0]      v,
  output logic [8:0]      hf,
  output logic [7:0]      vf,
  output logic            LHBL,
  output logic            LVBL,
  output logic            HS,
  output logic            VS,
  output logic [NIRQ-1:0] irq_pend,
  output logic            int_n
);

  logic            h_wrap;
  logic [8:0]      h_nxt;
  logic [8:0]      v_nxt;
  logic [NIRQ-1:0] irq_hit;

  // Next-count values. All edge detection below compares against the value
  // h is about to take, so "h becomes X" is a single equality test.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    h_wrap  = (h == HCNT_END);
    h_nxt   = h_wrap ? 9'd0 : h + 9'd1;
    v_nxt   = v;
    irq_hit = '0;
    if (h_wrap) begin
      v_nxt = (v == VCNT_END) ? 9'd0 : v + 9'd1;
    end
    // A line beyond VCNT_END can never equal v_nxt, so such a channel
    // never fires; channels sharing a line fire together.
    for (int k = 0; k < NIRQ; k++) begin
      irq_hit[k] = h_wrap && (v_nxt == IRQ_LINES[k*9 +: 9]);
    end
  end

  assign hf = h ^ {9{flip}};
  assign vf = v[7:0] ^ {8{flip}};

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      h        <= 9'd0;
      v        <= 9'd0;
      LHBL     <= 1'b0;
      LVBL     <= 1'b0;
      HS       <= 1'b0;
      VS       <= 1'b0;
      irq_pend <= '0;
      int_n    <= 1'b1;
    end else begin
      if (pxl_cen) begin
        h <= h_nxt;
        v <= v_nxt;

        // Edge-triggered toggles make wrap-around ranges (END < START) free.
        if (h_nxt == HB_START)    LHBL <= 1'b0;
        else if (h_nxt == HB_END) LHBL <= 1'b1;

        if (h_nxt == HS_START)    HS <= 1'b1;
        else if (h_nxt == HS_END) HS <= 1'b0;

        // Vertical strobes change only at the horizontal reference points,
        // tested against the line currently being drawn.
        if (h_nxt == HB_START) begin
          if (v == VB_START)    LVBL <= 1'b0;
          else if (v == VB_END) LVBL <= 1'b1;
        end

        if (h_nxt == HS_START) begin
          if (v == VS_START)    VS <= 1'b1;
          else if (v == VS_END) VS <= 1'b0;
        end
      end

`ifdef JTPANG_IRQACK_EN
      // Ack clears on any clk edge; a set arriving on the same edge wins.
      irq_pend <= (irq_pend & ~irq_ack) | (pxl_cen ? irq_hit : '0);
`else
      // One-line pulse: each line start reloads the flags from the hits.
      if (pxl_cen && h_wrap) irq_pend <= irq_hit;
`endif

      // Refreshed every clk so the interrupt follows the flags one clk late
      // even while the pixel enable is low.
      int_n <= ~|(irq_pend & irq_en);
    end
  end

`ifndef JTPANG_IRQACK_EN
  logic unused_ack;
  assign unused_ack = ^irq_ack;
`endif

endmodule
